tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL provide parameter W, default 1: width in bits of each channel slot and of data_in.
REQ-002 SHALL provide port clk, input, 1: single rising-edge clock for all state.
REQ-003 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port en, input, 1: slot strobe; data_in and frame_sync are sampled only on edges where en=1.
REQ-005 SHALL provide port frame_sync, input, 1: marks the slot-0 sample of a frame.
REQ-006 SHALL provide port data_in, input, W: serial TDM slot data.
REQ-007 SHALL provide ports d0, d1, d2, d3, output, W each: registered demultiplexed channel words.
REQ-008 SHALL provide port frame_valid, output, 1: one-cycle pulse when d0..d3 have just been updated.
REQ-009 SHALL provide port sync_err, output, 1: one-cycle pulse when frame_sync arrives at an unexpected slot.
REQ-010 SHALL provide port parity_err, output, 1: one-cycle pulse when a frame fails its parity check.
REQ-011 SHALL provide port locked, output, 1: high while the FSM is in SYNC.

Function
REQ-012 SHALL implement a two-state FSM, HUNT and SYNC, with a slot counter covering 0..LAST; LAST=3, or 4 when parity is enabled.
REQ-013 In HUNT, an edge with en=1 and frame_sync=1 SHALL store data_in into the slot-0 shadow register, set slot=1 and go to SYNC; all other samples SHALL be ignored.
REQ-014 In SYNC, each en=1 edge SHALL store data_in into the shadow register for the current slot and advance the slot counter, wrapping LAST->0.
REQ-015 The edge that samples slot 3 (no parity) or slot 4 (parity) SHALL load d0..d3 from the shadows, with d3 or the parity slot taken directly from data_in, and SHALL set frame_valid high for exactly the following cycle.
REQ-016 Latency: d0..d3 SHALL be valid in the cycle after the last slot's sampling edge, coincident with frame_valid.
REQ-017 In SYNC, frame_sync=1 with en=1 at slot 0 SHALL be treated as normal; its absence at slot 0 SHALL be tolerated (freewheel).
REQ-018 In SYNC, frame_sync=1 with en=1 at slot!=0 SHALL pulse sync_err, discard the partial frame, store data_in as slot 0 and set slot=1 (realign); d0..d3 SHALL NOT change.
REQ-019 When en=0, all state SHALL hold, frame_sync SHALL be ignored, and pulse outputs SHALL be 0.
REQ-020 Pulses SHALL never exceed one cycle, even when en is held high continuously.

Reset
REQ-021 While rst_n=0, the block SHALL reset immediately, not on a clock edge: FSM=HUNT, slot=0, shadows=0, d0..d3=0, frame_valid=0, sync_err=0, parity_err=0, locked=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait in HUNT for frame_sync.

Configuration
REQ-023 Macro TDM_DEMUX_PARITY_EN defined: the frame SHALL be 5 slots, with slot 4 carrying d0^d1^d2^d3 (bitwise, W bits).
REQ-024 With the macro defined, a frame whose slot 4 matches SHALL behave per REQ-015; on a mismatch, parity_err SHALL pulse in place of frame_valid and d0..d3 SHALL hold their previous values.
REQ-025 Macro undefined: the frame SHALL be 4 slots and parity_err SHALL be tied to 0.

Structure
REQ-026 A shared package tdm_pkg SHALL hold the FSM state encoding (HUNT, SYNC), the constants NUM_CH=4 and SLOT_W=3, and the LAST-slot constant selected by the macro.
REQ-027 The slot counter with wrap and realign-load SHALL be a sub-module, tdm_slot_cnt; the FSM and datapath SHALL remain in tdm_demux.

Verification
REQ-028 Reset, then en=1, frame_sync on first sample, data 1,0,0,0 (W=1) -> d0..d3=1,0,0,0 and frame_valid one cycle after the 4th sample; locked=1 from the first sample.
REQ-029 Three back-to-back frames 1000/0100/0001 with frame_sync every 4th sample -> three frame_valid pulses exactly 4 cycles apart, with matching outputs.
REQ-030 frame_sync re-asserted at slot 2 -> sync_err pulses once, d0..d3 unchanged, and the next frame_valid falls 4 samples after the realign.
REQ-031 en toggled 1/0 on alternate cycles during a frame -> the same d0..d3 as with continuous en; frame_valid occurs after the 4th enabled sample.
REQ-032 rst_n pulsed low after 2 slots -> all outputs 0 immediately, locked=0; data without frame_sync produces no frame_valid.
REQ-033 With TDM_DEMUX_PARITY_EN, frame 1,1,0,0 with parity 0 -> frame_valid; the same frame with parity 1 -> parity_err pulses and d0..d3 hold.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// Define TDM_DEMUX_PARITY_EN to append a parity slot to every frame.
package tdm_pkg;

    typedef enum logic [0:0] {
        StHunt,
        StSync
    } state_e;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 3;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned LAST_SLOT = 4;
`else
    localparam int unsigned LAST_SLOT = 3;
`endif

    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(LAST_SLOT);

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM demultiplexer: advances and wraps at the last slot,
// or loads slot 1 when a new frame is aligned on a frame_sync sample.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = SLOT_W'(1);
        end else if (adv_i) begin
            slot_d = (slot_q == LAST_IDX) ? '0 : slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// Four-channel TDM demultiplexer with frame-sync hunting and realignment.
// Define TDM_DEMUX_PARITY_EN for a fifth slot carrying the XOR of the four channels.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         frame_sync,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         parity_err,
    output logic         locked
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot;
    logic              slot_load, slot_adv;
    // The last slot is consumed straight from data_in, so it needs no shadow.
    logic [W-1:0]      shadow_q [LAST_SLOT];
    logic [W-1:0]      shadow_d [LAST_SLOT];
    logic [W-1:0]      d_q [NUM_CH];
    logic [W-1:0]      d_d [NUM_CH];
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

`ifdef TDM_DEMUX_PARITY_EN
    logic              parity_err_q, parity_err_d;
    logic [W-1:0]      exp_parity;
    assign exp_parity = shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3];
`endif

    tdm_slot_cnt u_slot_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (slot_load),
        .adv_i  (slot_adv),
        .slot_o (slot)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        d_d           = d_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        slot_load     = 1'b0;
        slot_adv      = 1'b0;
        if (en) begin
            unique case (state_q)
                StHunt: begin
                    if (frame_sync) begin
                        shadow_d[0] = data_in;
                        slot_load   = 1'b1;
                        state_d     = StSync;
                    end
                end
                StSync: begin
                    if (frame_sync && (slot != '0)) begin
                        // Realign: the new sample becomes slot 0 of a fresh frame.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = data_in;
                        slot_load   = 1'b1;
                    end else begin
                        slot_adv = 1'b1;
                        for (int unsigned i = 0; i < LAST_SLOT; i++) begin
                            if (slot == SLOT_W'(i)) begin
                                shadow_d[i] = data_in;
                            end
                        end
                        if (slot == LAST_IDX) begin
`ifdef TDM_DEMUX_PARITY_EN
                            if (data_in == exp_parity) begin
                                for (int unsigned i = 0; i < NUM_CH; i++) begin
                                    d_d[i] = shadow_q[i];
                                end
                                frame_valid_d = 1'b1;
                            end else begin
                                parity_err_d = 1'b1;
                            end
`else
                            d_d[0]        = shadow_q[0];
                            d_d[1]        = shadow_q[1];
                            d_d[2]        = shadow_q[2];
                            d_d[3]        = data_in;
                            frame_valid_d = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            shadow_q      <= '{default: '0};
            d_q           <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign d0          = d_q[0];
    assign d1          = d_q[1];
    assign d2          = d_q[2];
    assign d3          = d_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == StSync);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

    localparam int unsigned W = 4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         frame_sync;
    logic [W-1:0] data_in;
    logic [W-1:0] d0, d1, d2, d3;
    logic         frame_valid, sync_err, parity_err, locked;

    tdm_demux #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_sync  (frame_sync),
        .data_in     (data_in),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .parity_err  (parity_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: the samples collected so far for the current frame; slot = q.size().
    logic [W-1:0] q [$];
    bit           m_locked;
    logic [W-1:0] m_d [4];
    bit           m_fv, m_se, m_pe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 1'b0;
        for (int i = 0; i < 4; i++) m_d[i] = '0;
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic f, input logic [W-1:0] x);
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (e) begin
            if (!m_locked) begin
                if (f) begin
                    q        = {x};
                    m_locked = 1'b1;
                end
            end else if (f && q.size() != 0) begin
                m_se = 1'b1;
                q    = {x};
            end else begin
                q.push_back(x);
                if (q.size() == FRAME) begin
                    if (FRAME == 5 && q[FRAME-1] != (q[0] ^ q[1] ^ q[2] ^ q[3])) begin
                        m_pe = 1'b1;
                    end else begin
                        for (int i = 0; i < 4; i++) m_d[i] = q[i];
                        m_fv = 1'b1;
                    end
                    q.delete();
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("d0", d0, m_d[0]);
        chk("d1", d1, m_d[1]);
        chk("d2", d2, m_d[2]);
        chk("d3", d3, m_d[3]);
        chk("frame_valid", frame_valid, m_fv);
        chk("sync_err", sync_err, m_se);
        chk("parity_err", parity_err, m_pe);
        chk("locked", locked, m_locked);
    endtask

    task automatic tick(input logic e, input logic f, input logic [W-1:0] x);
        en         = e;
        frame_sync = f;
        data_in    = x;
        @(posedge clk);
        model_step(e, f, x);
        cyc++;
        #1;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d0"}, d0, 0);
        chk({tag, "_d1"}, d1, 0);
        chk({tag, "_d2"}, d2, 0);
        chk({tag, "_d3"}, d3, 0);
        chk({tag, "_fv"}, frame_valid, 0);
        chk({tag, "_se"}, sync_err, 0);
        chk({tag, "_pe"}, parity_err, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without an edge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] dd,
                              input bit bad_par);
        tick(1'b1, 1'b1, a);
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, c);
        tick(1'b1, 1'b0, dd);
        if (FRAME == 5) tick(1'b1, 1'b0, (a ^ b ^ c ^ dd) ^ W'(bad_par));
    endtask

    initial begin
        int t_prev;
        logic e, f;
        logic [W-1:0] x;

        rst_n      = 1'b0;
        en         = 1'b0;
        frame_sync = 1'b0;
        data_in    = '0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // First frame 1,0,0,0 with locking on the first sample.
        tick(1'b1, 1'b1, 4'd1);
        chk("lock_first", locked, 1);
        chk("fv_early", frame_valid, 0);
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        if (FRAME == 5) tick(1'b1, 1'b0, 4'd1);
        chk("f1_fv", frame_valid, 1);
        chk("f1_d0", d0, 1);
        chk("f1_d1", d1, 0);
        chk("f1_d3", d3, 0);
        tick(1'b0, 1'b0, 4'd0);
        chk("f1_fv_one_cycle", frame_valid, 0);

        // Back-to-back frames with continuous en.
        t_prev = -1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: send_frame(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
                1: send_frame(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
                default: send_frame(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
            endcase
            chk("b2b_fv", frame_valid, 1);
            if (t_prev >= 0) chk("b2b_spacing", cyc - t_prev, FRAME);
            t_prev = cyc;
        end
        chk("b2b_d3", d3, 1);
        chk("b2b_d1", d1, 0);

        // Realign on frame_sync at slot 2.
        tick(1'b1, 1'b1, 4'd1);
        tick(1'b1, 1'b0, 4'd1);
        tick(1'b1, 1'b1, 4'd0);
        chk("realign_se", sync_err, 1);
        chk("realign_d0_hold", d0, 0);
        chk("realign_d3_hold", d3, 1);
        tick(1'b1, 1'b0, 4'd1);
        chk("realign_se_one_cycle", sync_err, 0);
        tick(1'b1, 1'b0, 4'd1);
        tick(1'b1, 1'b0, 4'd1);
        if (FRAME == 5) tick(1'b1, 1'b0, 4'd1);
        chk("realign_fv", frame_valid, 1);
        chk("realign_d0", d0, 0);
        chk("realign_d1", d1, 1);
        chk("realign_d3", d3, 1);

        // Alternating en; the disabled frame_sync must be ignored.
        tick(1'b1, 1'b1, 4'd1);
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 4'd1);
        tick(1'b1, 1'b0, 4'd1);
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd1);
        if (FRAME == 5) begin
            tick(1'b0, 1'b0, 4'd0);
            tick(1'b1, 1'b0, 4'd1);
        end
        chk("gated_fv", frame_valid, 1);
        chk("gated_d0", d0, 1);
        chk("gated_d1", d1, 0);
        chk("gated_d2", d2, 1);
        chk("gated_d3", d3, 1);

        // Reset mid-frame, then data without frame_sync stays unlocked.
        tick(1'b1, 1'b1, 4'd1);
        tick(1'b1, 1'b0, 4'd1);
        mid_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b1, 1'b0, 4'd1);
            chk("hunt_no_fv", frame_valid, 0);
            chk("hunt_unlocked", locked, 0);
        end

        if (FRAME == 5) begin
            send_frame(4'd1, 4'd1, 4'd0, 4'd0, 1'b0);
            chk("par_ok_fv", frame_valid, 1);
            chk("par_ok_d1", d1, 1);
            send_frame(4'd1, 4'd1, 4'd0, 4'd0, 1'b1);
            chk("par_bad_pe", parity_err, 1);
            chk("par_bad_fv", frame_valid, 0);
            send_frame(4'd0, 4'd0, 4'd1, 4'd1, 1'b1);
            chk("par_bad_pe2", parity_err, 1);
            chk("par_hold_d0", d0, 1);
            chk("par_hold_d2", d2, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) mid_reset();
            e = ($urandom_range(0, 3) != 0);
            if (!m_locked) f = ($urandom_range(0, 3) == 0);
            else if (q.size() == 0) f = 1'($urandom_range(0, 1));
            else f = ($urandom_range(0, 19) == 0);
            x = W'($urandom);
            if (FRAME == 5 && m_locked && q.size() == 4 && $urandom_range(0, 1) == 1) begin
                x = q[0] ^ q[1] ^ q[2] ^ q[3];
            end
            tick(e, f, x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
